// File: rtl/axi4_lite_read_block_collector_if.sv
// Bus bundle for axi4_lite_read_block_collector: block request, per-beat
// read data, assembled block output and the critical-word side channel.
// slave = collector side, master = requester/consumer side.
interface axi4_lite_read_block_collector_if #(
    parameter int words_per_block_p = 8,
    parameter int axi_addr_width_p  = 28,
    parameter int axi_data_width_p  = 64
);
    logic [axi_addr_width_p-1:0]                    req_addr_i;
    logic                                           req_v_i;
    logic                                           req_ready_and_o;
    logic [axi_data_width_p-1:0]                    r_data_i;
    logic [1:0]                                     r_resp_i;
    logic                                           r_v_i;
    logic                                           r_ready_and_o;
    logic [words_per_block_p*axi_data_width_p-1:0]  block_data_o;
    logic [axi_addr_width_p-1:0]                    block_addr_o;
    logic                                           block_err_o;
    logic                                           block_v_o;
    logic                                           block_ready_and_i;
    logic [axi_data_width_p-1:0]                    crit_data_o;
    logic                                           crit_v_o;

    modport slave (
        input  req_addr_i, req_v_i, r_data_i, r_resp_i, r_v_i, block_ready_and_i,
        output req_ready_and_o, r_ready_and_o, block_data_o, block_addr_o,
               block_err_o, block_v_o, crit_data_o, crit_v_o
    );

    modport master (
        output req_addr_i, req_v_i, r_data_i, r_resp_i, r_v_i, block_ready_and_i,
        input  req_ready_and_o, r_ready_and_o, block_data_o, block_addr_o,
               block_err_o, block_v_o, crit_data_o, crit_v_o
    );
endinterface

// File: rtl/axi4_lite_read_block_collector.sv
// Collects the words_per_block_p single-word AXI4-lite read beats of one
// cache-block fill. Beats arrive critical-word-first and wrap around the
// block; each is stored at its true word position and the aligned block is
// presented once complete, with a sticky error flag for any non-OKAY beat.
// Optional: define AXI4_LITE_READ_BLOCK_COLLECTOR_CRIT_FWD_EN to forward the
// first beat of each fill on crit_data_o with a one-cycle crit_v_o pulse.
module axi4_lite_read_block_collector #(
    parameter int words_per_block_p = 8,
    parameter int axi_addr_width_p  = 28,
    parameter int axi_data_width_p  = 64
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    axi4_lite_read_block_collector_if.slave  bus
);

    localparam int byte_off_lp = $clog2(axi_data_width_p / 8);
    localparam int word_w_lp   = $clog2(words_per_block_p);
    localparam int low_w_lp    = byte_off_lp + word_w_lp;

    localparam logic [axi_addr_width_p-1:0] align_mask_lp =
        ~((axi_addr_width_p'(1) << low_w_lp) - axi_addr_width_p'(1));
    localparam logic [word_w_lp-1:0] last_cnt_lp = word_w_lp'(words_per_block_p - 1);

    typedef enum logic [1:0] {
        e_idle    = 2'd0,
        e_collect = 2'd1,
        e_output  = 2'd2
    } state_e;

    state_e                                            r_state;
    state_e                                            w_state_next;
    logic [words_per_block_p-1:0][axi_data_width_p-1:0] r_buf;
    logic [axi_addr_width_p-1:0]                       r_block_addr;
    logic [word_w_lp-1:0]                              r_wrap_idx;
    logic [word_w_lp-1:0]                              r_cnt;
    logic                                              r_err;

    logic w_req_ready;
    logic w_r_ready;
    logic w_block_v;
    logic w_req_hs;
    logic w_beat_hs;
    logic w_last_beat;

    assign w_req_hs    = bus.req_v_i & w_req_ready;
    assign w_beat_hs   = bus.r_v_i & w_r_ready;
    assign w_last_beat = w_beat_hs & (r_cnt == last_cnt_lp);

    // State register; reset aborts any fill in progress.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: request -> collect N beats -> hold block until consumed.
    // NOTE: the default assignment first means every path assigns
    // w_state_next, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_idle:    if (w_req_hs)              w_state_next = e_collect;
            e_collect: if (w_last_beat)           w_state_next = e_output;
            e_output:  if (bus.block_ready_and_i) w_state_next = e_idle;
            default:                              w_state_next = e_idle;
        endcase
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        w_req_ready = 1'b0;
        w_r_ready   = 1'b0;
        w_block_v   = 1'b0;
        case (r_state)
            e_idle:    w_req_ready = 1'b1;
            e_collect: w_r_ready   = 1'b1;
            e_output:  w_block_v   = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: latch the aligned address on request, scatter beats into place.
    // NOTE: the block buffer is a flop array, not a RAM, and is reset so that
    // block_data_o reads zero as soon as reset asserts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_buf        <= '0;
            r_block_addr <= '0;
            r_wrap_idx   <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else if (w_req_hs) begin
            r_block_addr <= bus.req_addr_i & align_mask_lp;
            r_wrap_idx   <= bus.req_addr_i[byte_off_lp +: word_w_lp];
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else if (w_beat_hs) begin
            r_buf[r_wrap_idx] <= bus.r_data_i;
            r_wrap_idx        <= r_wrap_idx + word_w_lp'(1);
            r_cnt             <= r_cnt + word_w_lp'(1);
            r_err             <= r_err | (bus.r_resp_i != 2'b00);
        end
    end

    assign bus.req_ready_and_o = w_req_ready;
    assign bus.r_ready_and_o   = w_r_ready;
    assign bus.block_v_o       = w_block_v;
    assign bus.block_data_o    = r_buf;
    assign bus.block_addr_o    = r_block_addr;
    assign bus.block_err_o     = r_err;

`ifdef AXI4_LITE_READ_BLOCK_COLLECTOR_CRIT_FWD_EN
    logic [axi_data_width_p-1:0] r_crit_data;
    logic                        r_crit_v;

    // Forward the first beat of each fill with a one-cycle valid pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_crit_data <= '0;
            r_crit_v    <= 1'b0;
        end else begin
            r_crit_v <= w_beat_hs & (r_cnt == '0);
            if (w_beat_hs && (r_cnt == '0)) begin
                r_crit_data <= bus.r_data_i;
            end
        end
    end

    assign bus.crit_data_o = r_crit_data;
    assign bus.crit_v_o    = r_crit_v;
`else
    assign bus.crit_data_o = '0;
    assign bus.crit_v_o    = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_read_block_collector.sv
// Directed bench for axi4_lite_read_block_collector. A transaction-level
// model (word array filled at (start + k) mod N, sticky error, busy/pending
// flags) is compared against the DUT on every falling edge; a few literal
// expectations pin the model. Inputs change 1ns after the rising edge.
module tb_axi4_lite_read_block_collector;

    localparam int N  = 8;
    localparam int W  = 64;
    localparam int AW = 28;

    logic clk;
    logic rst_n;

    axi4_lite_read_block_collector_if #(
        .words_per_block_p(N), .axi_addr_width_p(AW), .axi_data_width_p(W)
    ) bus ();

    axi4_lite_read_block_collector #(
        .words_per_block_p(N), .axi_addr_width_p(AW), .axi_data_width_p(W)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [W-1:0]  m_words [N];
    logic [AW-1:0] m_addr;
    logic          m_err;
    int            m_start;
    int            m_k;
    logic          m_active;
    logic          m_pending;
    logic          m_crit_exp;
    logic [W-1:0]  m_crit_data;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_block();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_words[i];
        return v;
    endfunction

    function automatic logic [W-1:0] dut_word(input int i);
        return bus.block_data_o[i*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_words[i] = '0;
        m_addr      = '0;
        m_err       = 1'b0;
        m_start     = 0;
        m_k         = 0;
        m_active    = 1'b0;
        m_pending   = 1'b0;
        m_crit_exp  = 1'b0;
        m_crit_data = '0;
    endtask

    task automatic model_accept(input logic [AW-1:0] a);
        m_addr   = {a[AW-1:6], 6'b0};
        m_start  = int'(a[5:3]);
        m_k      = 0;
        m_err    = 1'b0;
        m_active = 1'b1;
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic request(input logic [AW-1:0] a);
        bus.req_addr_i = a;
        bus.req_v_i    = 1'b1;
        @(posedge clk); #1;
        model_accept(a);
        bus.req_v_i    = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [1:0] resp, input bit gap);
        bus.r_data_i = d;
        bus.r_resp_i = resp;
        bus.r_v_i    = 1'b1;
        @(posedge clk); #1;
        if (m_k == 0) begin
            m_crit_exp  = 1'b1;
            m_crit_data = d;
        end
        m_words[(m_start + m_k) % N] = d;
        m_err = m_err | (resp != 2'b00);
        m_k++;
        if (m_k == N) begin
            m_active  = 1'b0;
            m_pending = 1'b1;
        end
        bus.r_v_i    = 1'b0;
        bus.r_resp_i = 2'b00;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic consume(input int hold);
        bus.block_ready_and_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        bus.block_ready_and_i = 1'b1;
        @(posedge clk); #1;
        m_pending = 1'b0;
        bus.block_ready_and_i = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", bus.req_ready_and_o, !m_active && !m_pending);
            check("r_ready", bus.r_ready_and_o, m_active);
            check("block_v", bus.block_v_o, m_pending);
            if (m_pending && bus.block_v_o) begin
                check("block_data", bus.block_data_o, model_block());
                check("block_addr", bus.block_addr_o, m_addr);
                check("block_err", bus.block_err_o, m_err);
            end
`ifdef AXI4_LITE_READ_BLOCK_COLLECTOR_CRIT_FWD_EN
            check("crit_v", bus.crit_v_o, m_crit_exp);
            check("crit_data", bus.crit_data_o, m_crit_data);
            m_crit_exp = 1'b0;
`else
            check("crit_v_tied", bus.crit_v_o, 1'b0);
            check("crit_data_tied", bus.crit_data_o, '0);
`endif
        end
    end

    initial begin
        model_reset();
        rst_n                 = 1'b0;
        bus.req_addr_i        = '0;
        bus.req_v_i           = 1'b0;
        bus.r_data_i          = '0;
        bus.r_resp_i          = 2'b00;
        bus.r_v_i             = 1'b0;
        bus.block_ready_and_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_block_v", bus.block_v_o, 1'b0);
        check("rst_r_ready", bus.r_ready_and_o, 1'b0);
        check("rst_req_ready", bus.req_ready_and_o, 1'b1);
        check("rst_block_data", bus.block_data_o, '0);
        check("rst_block_addr", bus.block_addr_o, '0);
        check("rst_block_err", bus.block_err_o, 1'b0);
        check("rst_crit_v", bus.crit_v_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wrapped fill starting at word 3, back-to-back beats
        request(28'h0001258);
        send_beat(64'hA0, 2'b00, 1'b0);
`ifdef AXI4_LITE_READ_BLOCK_COLLECTOR_CRIT_FWD_EN
        check("lit_crit_v", bus.crit_v_o, 1'b1);
        check("lit_crit_data", bus.crit_data_o, 64'hA0);
`else
        check("lit_crit_v_off", bus.crit_v_o, 1'b0);
`endif
        for (int i = 1; i < N; i++) send_beat(64'hA0 + 64'(i), 2'b00, 1'b0);
        check("lit_wrap_v", bus.block_v_o, 1'b1);
        check("lit_wrap_addr", bus.block_addr_o, 28'h0001240);
        check("lit_wrap_w3", dut_word(3), 64'hA0);
        check("lit_wrap_w7", dut_word(7), 64'hA4);
        check("lit_wrap_w0", dut_word(0), 64'hA5);
        check("lit_wrap_w2", dut_word(2), 64'hA7);
        check("lit_wrap_err", bus.block_err_o, 1'b0);
        consume(0);

        // Aligned fill with gaps between beats, then surplus beats during output
        request(28'h0000040);
        for (int i = 0; i < N; i++) send_beat(64'hB0 + 64'(i), 2'b00, i != N - 1);
        check("lit_align_v", bus.block_v_o, 1'b1);
        bus.r_data_i = 64'hEE;
        bus.r_v_i    = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.r_v_i = 1'b0;
        check("lit_align_w0", dut_word(0), 64'hB0);
        check("lit_align_w7", dut_word(7), 64'hB7);
        check("lit_align_addr", bus.block_addr_o, 28'h0000040);
        consume(1);

        // Error on beat 5 only
        request(28'h0000088);
        for (int i = 0; i < N; i++) send_beat(64'hD0 + 64'(i), (i == 5) ? 2'b10 : 2'b00, 1'b0);
        check("lit_err_set", bus.block_err_o, 1'b1);
        check("lit_err_w1", dut_word(1), 64'hD0);
        check("lit_err_w0", dut_word(0), 64'hD7);

        // Backpressure with a pending request and a stray beat
        bus.req_addr_i = 28'h00000C0;
        bus.req_v_i    = 1'b1;
        bus.r_data_i   = 64'hFF;
        bus.r_v_i      = 1'b1;
        consume(5);
        @(posedge clk); #1;
        model_accept(28'h00000C0);
        bus.req_v_i = 1'b0;
        bus.r_v_i   = 1'b0;
        check("lit_next_req_taken", bus.r_ready_and_o, 1'b1);
        for (int i = 0; i < N; i++) send_beat(64'hE0 + 64'(i), 2'b00, 1'b0);
        check("lit_clean_err", bus.block_err_o, 1'b0);
        check("lit_clean_w0", dut_word(0), 64'hE0);
        consume(0);

        // Reset in the middle of a fill
        request(28'h0001258);
        for (int i = 0; i < 3; i++) send_beat(64'hF0 + 64'(i), 2'b00, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("lit_midrst_block_v", bus.block_v_o, 1'b0);
        check("lit_midrst_r_ready", bus.r_ready_and_o, 1'b0);
        check("lit_midrst_data", bus.block_data_o, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        request(28'h0001258);
        for (int i = 0; i < N; i++) send_beat(64'hC0 + 64'(i), 2'b00, 1'b0);
        check("lit_post_rst_addr", bus.block_addr_o, 28'h0001240);
        check("lit_post_rst_w3", dut_word(3), 64'hC0);
        check("lit_post_rst_w2", dut_word(2), 64'hC7);
        consume(0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_block_collector.md
Name: axi4_lite_read_block_collector

Overview:
- Downstream consumer of the per-beat AXI4-lite read address sequencer: gathers the N single-word read-data beats of one cache-block fill.
- Beats arrive in wrap-around (critical-word-first) order; the block stores each beat at its true word position and presents one aligned, block-ordered fill to the cache/LCE side.
- Accepts the original block request address to know the starting word, and reports an error if any beat responded non-OKAY.

Parameters:
- words_per_block_p, 8, words per block; power of two, >= 2.
- axi_addr_width_p, 28, AXI address width in bits.
- axi_data_width_p, 64, AXI data/word width in bits; power of two, >= 8.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_addr_i  in  axi_addr_width_p  block request address; critical-word address, byte-offset bits ignored.
- req_v_i  in  1  request valid.
- req_ready_and_o  out  1  request ready (valid-then-ready/and handshake).
- r_data_i  in  axi_data_width_p  read-data beat.
- r_resp_i  in  2  AXI response; 2'b00 = OKAY.
- r_v_i  in  1  beat valid.
- r_ready_and_o  out  1  beat ready.
- block_data_o  out  words_per_block_p*axi_data_width_p  assembled block; word i at [i*axi_data_width_p +: axi_data_width_p].
- block_addr_o  out  axi_addr_width_p  block-aligned address.
- block_err_o  out  1  any beat of this block was non-OKAY.
- block_v_o  out  1  block valid.
- block_ready_and_i  in  1  consumer ready.
- crit_data_o  out  axi_data_width_p  critical word; see Optional Feature.
- crit_v_o  out  1  critical-word pulse; see Optional Feature.

Behaviour:
- Field widths:
  - byte_off = $clog2(axi_data_width_p/8).
  - word_w = $clog2(words_per_block_p).
  - Word index = req_addr_i[byte_off +: word_w].
  - block_addr = req_addr_i with the low byte_off+word_w bits zeroed.
- Reset (asynchronous assert, synchronous deassert by the driving logic):
  - State goes to e_idle.
  - Buffer, block_addr_o, counters, block_err_o, crit_data_o and crit_v_o clear to 0.
  - block_v_o = 0 and r_ready_and_o = 0; req_ready_and_o = 1 once in e_idle.
  - Reset mid-fill aborts the fill; partial data is discarded.
- e_idle:
  - req_ready_and_o = 1, r_ready_and_o = 0.
  - On req_v_i & req_ready_and_o: latch block_addr, load wrap_idx = word index, set cnt = 0, clear err, go to e_collect.
  - Beats presented in e_idle are not accepted.
- e_collect:
  - r_ready_and_o = 1, req_ready_and_o = 0.
  - Each beat handshake: buffer[wrap_idx] <= r_data_i; wrap_idx <= wrap_idx+1 (mod words_per_block_p, natural word_w-bit wrap); cnt <= cnt+1; err <= err | (r_resp_i != 0).
  - On the handshake with cnt == words_per_block_p-1, go to e_output.
  - Gaps (r_v_i low) are allowed; there is no timeout.
- e_output:
  - block_v_o = 1; req_ready_and_o = 0, r_ready_and_o = 0.
  - block_data_o, block_addr_o and block_err_o are registered and stable while block_v_o = 1.
  - On block_ready_and_i: go to e_idle. The next request is accepted no earlier than the following cycle.
- Latency: block_v_o rises the cycle after the last beat handshake. Minimum request-to-request period is words_per_block_p+2 cycles.
- Buffer contents persist after the output handshake and are overwritten by the next fill; block_data_o is only meaningful while block_v_o = 1.
- Illegal state encodings return to e_idle.

Optional Feature:
- Macro: AXI4_LITE_READ_BLOCK_COLLECTOR_CRIT_FWD_EN.
- Defined:
  - On the first beat handshake of each fill, crit_data_o <= r_data_i and crit_v_o pulses high for exactly one cycle (the next cycle).
  - crit_v_o is valid-only with no backpressure; it is asserted even if r_resp_i is non-OKAY.
  - crit_data_o holds its value until the next fill's first beat.
- Undefined: crit_data_o and crit_v_o are tied to 0. All other behaviour is identical.

Test Plan:
- Wrapped fill:
  - Stimulus: req_addr_i = 28'h0001258 (word 3), beats 64'hA0..64'hA7, all OKAY, back-to-back.
  - Response: block_addr_o = 28'h0001240; word3 = A0, word4 = A1, ..., word7 = A4, word0 = A5, word1 = A6, word2 = A7; block_v_o high the cycle after the 8th beat; block_err_o = 0.
- Aligned fill:
  - Stimulus: req_addr_i = 28'h0000040, beats B0..B7 with r_v_i toggling every other cycle.
  - Response: word i = B(i); exactly 8 beats accepted; block_v_o high one cycle after the last beat.
- Backpressure:
  - Stimulus: block_ready_and_i held low 5 cycles in e_output while req_v_i = 1 and r_v_i = 1.
  - Response: block_v_o held; outputs stable; req_ready_and_o = 0 and r_ready_and_o = 0. After the handshake, the next request is accepted the following cycle.
- Error:
  - Stimulus: r_resp_i = 2'b10 on beat 5 only.
  - Response: all 8 beats consumed; block_err_o = 1. A following clean fill reports block_err_o = 0.
- Reset mid-fill:
  - Stimulus: reset_n_i low after 3 beats.
  - Response: block_v_o = 0, r_ready_and_o = 0 and block_data_o = 0 immediately, with no clock edge needed. After release, a new fill from 28'h0001258 completes correctly.
- Feature enabled:
  - Stimulus: wrapped fill with first beat A0.
  - Response: crit_v_o high exactly one cycle, the cycle after the first beat, with crit_data_o = A0. With the macro undefined, crit_v_o stays 0 throughout.
